// File: rtl/regfile_arbiter.sv
// Round-robin two-port arbiter in front of a single-read/single-write register file.
// After reset it zeroes every entry, then serves one request per cycle from port A or port B.
module regfile_arbiter #(
    parameter int REG_NUM = 256,
    localparam int AW = $clog2(REG_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_a_valid,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_wdata,
    output logic          o_a_ready,
    output logic          o_a_rvalid,
    output logic [31:0]   o_a_rdata,
    input  logic          i_b_valid,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [31:0]   i_b_wdata,
    output logic          o_b_ready,
    output logic          o_b_rvalid,
    output logic [31:0]   o_b_rdata,
    output logic          o_rf_wr_en,
    output logic [AW-1:0] o_rf_addr_wr,
    output logic [31:0]   o_rf_data_wr,
    output logic [AW-1:0] o_rf_addr_rd,
    input  logic [31:0]   i_rf_data_rd,
    output logic          o_init_done
);
    // Handshake: a request is accepted in the cycle where x_valid and x_ready are both high;
    // the requester holds valid/we/addr/wdata stable until then. A read answers with a
    // one-cycle x_rvalid pulse in the following cycle; a write produces no response.
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(REG_NUM - 1);

    state_t        state;
    logic [AW-1:0] init_cnt;
    logic          last_grant_b;
    logic          grant_a;
    logic          grant_b;

    // When both ports ask, the port that was not served last wins.
    assign grant_a   = (state == RUN) && i_a_valid && (!i_b_valid || last_grant_b);
    assign grant_b   = (state == RUN) && i_b_valid && (!i_a_valid || !last_grant_b);
    assign o_a_ready = grant_a;
    assign o_b_ready = grant_b;

    always_comb begin
        o_rf_wr_en   = 1'b0;
        o_rf_addr_wr = '0;
        o_rf_data_wr = '0;
        o_rf_addr_rd = '0;
        if (state == INIT) begin
            // Gated by rst so the sweep never writes while reset is held.
            o_rf_wr_en   = !rst;
            o_rf_addr_wr = init_cnt;
        end else if (grant_a) begin
            if (i_a_we) begin
                o_rf_wr_en   = 1'b1;
                o_rf_addr_wr = i_a_addr;
                o_rf_data_wr = i_a_wdata;
            end else begin
                o_rf_addr_rd = i_a_addr;
            end
        end else if (grant_b) begin
            if (i_b_we) begin
                o_rf_wr_en   = 1'b1;
                o_rf_addr_wr = i_b_addr;
                o_rf_data_wr = i_b_wdata;
            end else begin
                o_rf_addr_rd = i_b_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT;
            init_cnt     <= '0;
            last_grant_b <= 1'b1;
            o_init_done  <= 1'b0;
            o_a_rvalid   <= 1'b0;
            o_b_rvalid   <= 1'b0;
            o_a_rdata    <= '0;
            o_b_rdata    <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST) begin
                        state       <= RUN;
                        o_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (grant_a) begin
                        last_grant_b <= 1'b0;
                    end else if (grant_b) begin
                        last_grant_b <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
            o_a_rvalid <= grant_a && !i_a_we;
            o_b_rvalid <= grant_b && !i_b_we;
            if (grant_a && !i_a_we) begin
                o_a_rdata <= i_rf_data_rd;
            end
            if (grant_b && !i_b_we) begin
                o_b_rdata <= i_rf_data_rd;
            end
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with REG_NUM=16 and a behavioural register file model.
// Covers the init sweep, single read, write-then-read, contention and asynchronous reset.
module tb_regfile_arbiter;
    localparam int REG_NUM = 16;
    localparam int AW = $clog2(REG_NUM);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [31:0]   a_wdata = '0, b_wdata = '0;
    logic          a_ready, a_rvalid, b_ready, b_rvalid;
    logic [31:0]   a_rdata, b_rdata;
    logic          rf_wr_en, init_done;
    logic [AW-1:0] rf_addr_wr, rf_addr_rd;
    logic [31:0]   rf_data_wr, rf_data_rd;
    logic          preload = 1'b1;
    logic [31:0]   mem [REG_NUM];

    int n_vec = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    regfile_arbiter #(.REG_NUM(REG_NUM)) dut (
        .clk(clk), .rst(rst),
        .i_a_valid(a_valid), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_ready(a_ready), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
        .i_b_valid(b_valid), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_ready(b_ready), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
        .o_rf_wr_en(rf_wr_en), .o_rf_addr_wr(rf_addr_wr), .o_rf_data_wr(rf_data_wr),
        .o_rf_addr_rd(rf_addr_rd), .i_rf_data_rd(rf_data_rd), .o_init_done(init_done)
    );

    // register file model: synchronous write, combinational read
    always @(posedge clk) begin
        if (rf_wr_en) begin
            mem[rf_addr_wr] <= rf_data_wr;
        end else if (preload) begin
            for (int i = 0; i < REG_NUM; i++) mem[i] <= 32'hA5A5_0000 | i;
        end
    end
    assign rf_data_rd = mem[rf_addr_rd];

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks a complete sweep starting in the current cycle, then the first RUN cycle.
    task automatic sweep_check();
        for (int i = 0; i < REG_NUM; i++) begin
            @(negedge clk);
            check_vec("init_wr_en", 32'(rf_wr_en), 32'd1);
            check_vec("init_addr", 32'(rf_addr_wr), 32'(i));
            check_vec("init_data", rf_data_wr, 32'd0);
            check_vec("init_ready", {30'd0, a_ready, b_ready}, 32'd0);
            check_vec("init_done_low", 32'(init_done), 32'd0);
            next_cycle();
        end
        a_valid = 1'b0;
        @(negedge clk);
        check_vec("init_done_high", 32'(init_done), 32'd1);
        check_vec("run_idle_wr_en", 32'(rf_wr_en), 32'd0);
        for (int i = 0; i < REG_NUM; i++) check_vec("mem_zero", mem[i], 32'd0);
    endtask

    task automatic drive_a(input logic v, input logic we, input int addr, input logic [31:0] d);
        a_valid = v; a_we = we; a_addr = AW'(addr); a_wdata = d;
    endtask

    task automatic drive_b(input logic v, input logic we, input int addr, input logic [31:0] d);
        b_valid = v; b_we = we; b_addr = AW'(addr); b_wdata = d;
    endtask

    initial begin
        logic exp_a [4];
        int   cnt_a, cnt_b;
        exp_a[0] = 1'b1; exp_a[1] = 1'b0; exp_a[2] = 1'b1; exp_a[3] = 1'b0;

        // reset state, with A requesting the whole time
        drive_a(1'b1, 1'b0, 0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("rst_wr_en", 32'(rf_wr_en), 32'd0);
        check_vec("rst_addr_wr", 32'(rf_addr_wr), 32'd0);
        check_vec("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
        check_vec("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check_vec("rst_done", 32'(init_done), 32'd0);
        check_vec("preload", mem[7], 32'hA5A5_0007);
        next_cycle();
        preload = 1'b0;
        rst = 1'b0;
        sweep_check();

        // single read
        next_cycle();
        drive_a(1'b1, 1'b0, 5, 32'd0);
        @(negedge clk);
        check_vec("rd_a_ready", 32'(a_ready), 32'd1);
        check_vec("rd_b_ready", 32'(b_ready), 32'd0);
        check_vec("rd_addr", 32'(rf_addr_rd), 32'd5);
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk);
        check_vec("rd_a_rvalid", 32'(a_rvalid), 32'd1);
        check_vec("rd_a_rdata", a_rdata, 32'd0);
        check_vec("rd_b_rvalid", 32'(b_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_vec("rd_pulse_end", 32'(a_rvalid), 32'd0);

        // write-then-read across ports
        next_cycle();
        drive_a(1'b1, 1'b1, 3, 32'hDEAD_BEEF);
        @(negedge clk);
        check_vec("wr_ready", 32'(a_ready), 32'd1);
        check_vec("wr_en", 32'(rf_wr_en), 32'd1);
        check_vec("wr_addr", 32'(rf_addr_wr), 32'd3);
        check_vec("wr_data", rf_data_wr, 32'hDEAD_BEEF);
        next_cycle();
        a_valid = 1'b0;
        drive_b(1'b1, 1'b0, 3, 32'd0);
        @(negedge clk);
        check_vec("wr_no_resp", 32'(a_rvalid), 32'd0);
        check_vec("rb_ready", 32'(b_ready), 32'd1);
        next_cycle();
        b_valid = 1'b0;
        @(negedge clk);
        check_vec("rb_rvalid", 32'(b_rvalid), 32'd1);
        check_vec("rb_rdata", b_rdata, 32'hDEAD_BEEF);

        // seed entries 1 and 2; B goes last so round-robin starts with A
        next_cycle();
        drive_a(1'b1, 1'b1, 1, 32'h1111_1111);
        next_cycle();
        a_valid = 1'b0;
        drive_b(1'b1, 1'b1, 2, 32'h2222_2222);
        next_cycle();

        // contention: both hold reads for 4 cycles
        drive_a(1'b1, 1'b0, 1, 32'd0);
        drive_b(1'b1, 1'b0, 2, 32'd0);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_vec("ct_a_ready", 32'(a_ready), 32'(exp_a[k]));
            check_vec("ct_b_ready", 32'(b_ready), 32'(!exp_a[k]));
            check_vec("ct_addr_rd", 32'(rf_addr_rd), exp_a[k] ? 32'd1 : 32'd2);
            if (k > 0) begin
                check_vec("ct_a_rvalid", 32'(a_rvalid), 32'(exp_a[k-1]));
                cnt_a += int'(a_rvalid);
                cnt_b += int'(b_rvalid);
            end
            next_cycle();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        cnt_a += int'(a_rvalid);
        cnt_b += int'(b_rvalid);
        check_vec("ct_b_rvalid_last", 32'(b_rvalid), 32'd1);
        check_vec("ct_a_rdata", a_rdata, 32'h1111_1111);
        check_vec("ct_b_rdata", b_rdata, 32'h2222_2222);
        check_vec("ct_a_pulses", 32'(cnt_a), 32'd2);
        check_vec("ct_b_pulses", 32'(cnt_b), 32'd2);

        // reset during cycle 6 of INIT
        next_cycle();
        rst = 1'b1;
        #1;
        check_vec("mr_rdata", a_rdata, 32'd0);
        check_vec("mr_done", 32'(init_done), 32'd0);
        next_cycle();
        rst = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        check_vec("mr_cycle6_addr", 32'(rf_addr_wr), 32'd5);
        rst = 1'b1;
        #1;
        check_vec("mr_wr_en", 32'(rf_wr_en), 32'd0);
        check_vec("mr_addr_wr", 32'(rf_addr_wr), 32'd0);
        next_cycle();
        rst = 1'b0;
        sweep_check();

        // reset while a read response is due
        next_cycle();
        drive_a(1'b1, 1'b0, 3, 32'd0);
        @(negedge clk);
        check_vec("rv_ready", 32'(a_ready), 32'd1);
        rst = 1'b1;
        #1;
        check_vec("rv_ready_drop", 32'(a_ready), 32'd0);
        next_cycle();
        check_vec("rv_cancelled", 32'(a_rvalid), 32'd0);
        check_vec("rv_rdata", a_rdata, 32'd0);
        a_valid = 1'b0;
        rst = 1'b0;
        sweep_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port arbiter and initialiser for the single-read/single-write `Regfiles` storage block. After reset it sweeps every entry to zero. It then grants one requester per cycle, either port A or port B, using round-robin. It drives the register file's write and read ports and returns read data on a registered response.

## Interface
Parameters:
- REG_NUM, 256, number of 32-bit entries in the attached register file.
- AW, $clog2(REG_NUM), address width (derived, not overridden).

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  reset, asynchronous and active-high.
- i_a_valid  in  1  port A request valid.
- i_a_we  in  1  port A: 1 = write, 0 = read.
- i_a_addr  in  AW  port A entry address.
- i_a_wdata  in  32  port A write data.
- o_a_ready  out  1  port A request accepted this cycle.
- o_a_rvalid  out  1  port A read response valid (1-cycle pulse).
- o_a_rdata  out  32  port A read data, held until the next A read response.
- i_b_valid, i_b_we, i_b_addr, i_b_wdata, o_b_ready, o_b_rvalid, o_b_rdata: identical to port A, for port B.
- o_rf_wr_en  out  1  to register file i_wr_en.
- o_rf_addr_wr  out  AW  to register file i_addr_wr.
- o_rf_data_wr  out  32  to register file i_data_wr.
- o_rf_addr_rd  out  AW  to register file i_addr_rd.
- i_rf_data_rd  in  32  from register file o_data_rd (combinational read).
- o_init_done  out  1  high once the zero sweep is complete.

## Operation
- The FSM has two states: INIT and RUN. Reset enters INIT with init counter = 0, last_grant = B, and all response outputs at 0.
- INIT:
  - Each cycle: o_rf_wr_en=1, o_rf_addr_wr=counter, o_rf_data_wr=0; the counter increments.
  - When the counter equals REG_NUM-1, that write is issued and the next state is RUN.
  - o_a_ready=o_b_ready=0 throughout INIT; requests are ignored and not queued.
- RUN arbitration (combinational grant, registered pointer):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the port that is not last_grant.
  - last_grant updates to the granted port on each grant; with no request it holds.
- o_x_ready equals the grant for that port. A request is accepted when valid and ready are both high. At most one acceptance occurs per cycle.
- Granted write:
  - o_rf_wr_en=1, o_rf_addr_wr=addr, o_rf_data_wr=wdata.
  - No response pulse is generated.
- Granted read:
  - o_rf_addr_rd=addr.
  - i_rf_data_rd is captured into o_x_rdata at the same edge.
  - o_x_rvalid=1 for exactly the next cycle.
- No grant in RUN: o_rf_wr_en=0. o_rf_addr_wr, o_rf_data_wr and o_rf_addr_rd drive 0 whenever they are not in use.
- Requests are serialised, so a write and a read can never be issued in the same cycle. No bypass logic is needed.
- Address width: addresses are AW bits and are never out of range. The init counter is AW+1 bits wide, or compares against REG_NUM-1, so REG_NUM that is a power of two does not wrap early.

## Timing
- Reset values:
  - o_a_ready=o_b_ready=0, o_a_rvalid=o_b_rvalid=0, o_a_rdata=o_b_rdata=0, o_init_done=0.
  - o_rf_wr_en=0 while rst is asserted.
  - o_rf_* data and address outputs = 0.
- INIT lasts exactly REG_NUM cycles after rst deasserts. o_init_done rises in the first RUN cycle and stays high until the next reset.
- Read latency: request accepted in cycle N, so o_x_rvalid and o_x_rdata are valid in cycle N+1.
- Write commit: write accepted in cycle N, and the register file updates at the end of cycle N. A read accepted in cycle N+1 returns the new data.
- Back-to-back: the same port may be granted every cycle when it is the sole requester. When both ports request continuously, grants alternate A, B, A, B.
- Reset mid-operation (asynchronous): all outputs drop to reset values immediately.
  - Any pending rvalid is cancelled.
  - INIT restarts from address 0 after rst deasserts.
- The requester must hold valid, we, addr and wdata stable until ready is seen. The arbiter makes no fairness guarantee for a requester that withdraws valid.

## Test plan
- Init sweep: REG_NUM=16, preload the model with nonzero data, release rst, then check:
  - 16 consecutive writes to addresses 0..15 with data 0.
  - o_init_done=1 in cycle 17.
  - ready stays 0 throughout, even with i_a_valid held at 1.
- Single read: after init, A reads addr 5 -> o_rf_addr_rd=5, o_a_ready=1, then the next cycle o_a_rvalid=1 and o_a_rdata=0. o_b_rvalid stays 0.
- Write-then-read: A writes 0xDEADBEEF to addr 3 in cycle N; B reads addr 3 in cycle N+1 -> o_b_rdata=0xDEADBEEF in cycle N+2.
- Contention: A and B both hold reads (A addr 1, B addr 2) for 4 cycles -> grant order A, B, A, B; each port gets 2 rvalid pulses.
- Reset mid-traffic: assert rst during cycle 6 of INIT, and again while an rvalid pulse is due -> outputs zero immediately, the rvalid pulse is never seen, and INIT restarts at address 0 with the full REG_NUM sweep.
